// File: rtl/mem_arbiter_if.sv
// Bundle of request, grant, completion and memory-side signals shared by mem_arbiter
// and the agents around it (fetch unit, data unit, memory).
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_wr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    modport slave (
        input  if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_done, if_rdata, d_gnt, d_done, d_rdata,
        output mem_en, mem_wr, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_done, if_rdata, d_gnt, d_done, d_rdata,
        input  mem_en, mem_wr, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory between the instruction-fetch and data ports: fixed D priority with an
// anti-starvation override for IF, a fixed-latency wait, registered read data and done strobes.
module mem_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam int LW = $clog2(MEM_LAT + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [LW-1:0] lat_cnt;
    logic [SW-1:0] starve_cnt;
    logic          owner_d;
    logic          owner_wr;
    logic          pick_d;
    logic          grant_if;
    logic          grant_d;
    logic          mem_en_c;
    logic          mem_wr_c;
    logic [31:0]   mem_addr_c;
    logic [31:0]   mem_wdata_c;
    logic          if_done_q;
    logic          d_done_q;
    logic [31:0]   if_rdata_q;
    logic [31:0]   d_rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grants are combinational in IDLE so an access issues in the same cycle it is requested;
    // reset suppresses them so nothing reaches the memory while the arbiter is being cleared.
    always_comb begin
        state_nxt   = state;
        pick_d      = 1'b0;
        grant_if    = 1'b0;
        grant_d     = 1'b0;
        mem_en_c    = 1'b0;
        mem_wr_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        case (state)
            IDLE: begin
                if (!rst && (bus.if_req || bus.d_req)) begin
                    pick_d   = bus.d_req && !(bus.if_req && starve_cnt == SW'(STARVE_MAX));
                    grant_d  = pick_d;
                    grant_if = !pick_d;
                    mem_en_c = 1'b1;
                    if (pick_d) begin
                        mem_wr_c    = bus.d_wr;
                        mem_addr_c  = bus.d_addr;
                        mem_wdata_c = bus.d_wdata;
                    end else begin
                        mem_addr_c  = bus.if_addr;
                    end
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt == LW'(1)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The done strobe lands in the first IDLE cycle because it is registered from the last WAIT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_cnt    <= '0;
            owner_d    <= 1'b0;
            owner_wr   <= 1'b0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            if (grant_if || grant_d) begin
                lat_cnt  <= LW'(MEM_LAT);
                owner_d  <= grant_d;
                owner_wr <= grant_d && bus.d_wr;
            end else if (state == WAIT) begin
                lat_cnt <= lat_cnt - LW'(1);
                if (lat_cnt == LW'(1)) begin
                    if (owner_d) begin
                        d_done_q <= 1'b1;
                        if (!owner_wr) begin
                            d_rdata_q <= bus.mem_rdata;
                        end
                    end else begin
                        if_done_q  <= 1'b1;
                        if_rdata_q <= bus.mem_rdata;
                    end
                end
            end
        end
    end

    // Counts D wins while IF is kept waiting; an IF win or IF giving up restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!bus.if_req || grant_if) begin
            starve_cnt <= '0;
        end else if (grant_d && starve_cnt != SW'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    assign bus.if_gnt    = grant_if;
    assign bus.d_gnt     = grant_d;
    assign bus.if_done   = if_done_q;
    assign bus.d_done    = d_done_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_en    = mem_en_c;
    assign bus.mem_wr    = mem_wr_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;
    assign bus.busy      = (state == WAIT);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a MEM_LAT=1 and a MEM_LAT=3 instance, each with a latency-modelled
// memory, checked every cycle against a transaction-level model plus directed literal checks.
module tb_mem_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  if_req_v;
    logic [1:0]  d_req_v;
    logic [1:0]  d_wr_v;
    logic [31:0] if_addr_v  [2];
    logic [31:0] d_addr_v   [2];
    logic [31:0] d_wdata_v  [2];

    logic [1:0]  if_gnt_o;
    logic [1:0]  d_gnt_o;
    logic [1:0]  if_done_o;
    logic [1:0]  d_done_o;
    logic [1:0]  mem_en_o;
    logic [1:0]  mem_wr_o;
    logic [1:0]  busy_o;
    logic [31:0] if_rdata_o  [2];
    logic [31:0] d_rdata_o   [2];
    logic [31:0] mem_addr_o  [2];
    logic [31:0] mem_wdata_o [2];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEAD_BEEF;
        return a + 32'h5A5A_0000;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int L = (g == 0) ? 1 : 3;

        mem_arbiter_if bus ();

        mem_arbiter #(.MEM_LAT(L), .STARVE_MAX(STARVE_MAX)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );

        assign bus.if_req  = if_req_v[g];
        assign bus.if_addr = if_addr_v[g];
        assign bus.d_req   = d_req_v[g];
        assign bus.d_wr    = d_wr_v[g];
        assign bus.d_addr  = d_addr_v[g];
        assign bus.d_wdata = d_wdata_v[g];

        assign if_gnt_o[g]    = bus.if_gnt;
        assign d_gnt_o[g]     = bus.d_gnt;
        assign if_done_o[g]   = bus.if_done;
        assign d_done_o[g]    = bus.d_done;
        assign mem_en_o[g]    = bus.mem_en;
        assign mem_wr_o[g]    = bus.mem_wr;
        assign busy_o[g]      = bus.busy;
        assign if_rdata_o[g]  = bus.if_rdata;
        assign d_rdata_o[g]   = bus.d_rdata;
        assign mem_addr_o[g]  = bus.mem_addr;
        assign mem_wdata_o[g] = bus.mem_wdata;

        // Memory: writes land at the issue edge, read data emerges L cycles after issue.
        bit   [31:0] mem   [256];
        bit          wrote [256];
        logic [31:0] pipe  [L];

        always @(posedge clk) begin
            if (bus.mem_en && bus.mem_wr) begin
                mem[bus.mem_addr[9:2]]   <= bus.mem_wdata;
                wrote[bus.mem_addr[9:2]] <= 1'b1;
            end
            if (bus.mem_en && !bus.mem_wr) begin
                pipe[0] <= wrote[bus.mem_addr[9:2]] ? mem[bus.mem_addr[9:2]] : init_word(bus.mem_addr);
            end else begin
                pipe[0] <= 32'hBAD0_BAD0;
            end
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end

        assign bus.mem_rdata = pipe[L-1];
    end

    // Transaction-level model state: at most one access in flight, scheduled by cycle number.
    bit          pend_v    [2];
    bit          pend_if   [2];
    bit          pend_wr   [2];
    logic [31:0] pend_data [2];
    int          pend_done [2];
    int          starve    [2];
    logic [31:0] exp_ifr   [2];
    logic [31:0] exp_dr    [2];
    bit   [31:0] shadow    [2][256];
    bit          shadow_w  [2][256];

    task automatic check_bit(input string name, input int k, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s[%0d] cycle %0d: got %b expected %b", name, k, cyc, act, exp);
        end
    endtask

    task automatic check_word(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s[%0d] cycle %0d: got %h expected %h", name, k, cyc, act, exp);
        end
    endtask

    task automatic check_output(input int k);
        logic        e_ifg, e_dg, e_ifd, e_dd, e_en, e_wr, e_busy, win_d, grant;
        logic [31:0] e_addr, e_wd, a;
        if (rst) begin
            pend_v[k]  = 1'b0;
            starve[k]  = 0;
            exp_ifr[k] = '0;
            exp_dr[k]  = '0;
            return;
        end
        e_ifd = 1'b0;
        e_dd  = 1'b0;
        if (pend_v[k] && cyc == pend_done[k]) begin
            if (pend_if[k]) begin
                e_ifd      = 1'b1;
                exp_ifr[k] = pend_data[k];
            end else begin
                e_dd = 1'b1;
                if (!pend_wr[k]) exp_dr[k] = pend_data[k];
            end
            pend_v[k] = 1'b0;
        end
        e_busy = pend_v[k];
        grant  = !pend_v[k] && (if_req_v[k] || d_req_v[k]);
        win_d  = d_req_v[k] && !(if_req_v[k] && starve[k] == STARVE_MAX);
        e_ifg  = grant && !win_d;
        e_dg   = grant && win_d;
        e_en   = grant;
        e_wr   = e_dg && d_wr_v[k];
        e_addr = !grant ? 32'h0 : (win_d ? d_addr_v[k] : if_addr_v[k]);
        e_wd   = e_dg ? d_wdata_v[k] : 32'h0;

        check_bit ("if_gnt",    k, if_gnt_o[k],    e_ifg);
        check_bit ("d_gnt",     k, d_gnt_o[k],     e_dg);
        check_bit ("if_done",   k, if_done_o[k],   e_ifd);
        check_bit ("d_done",    k, d_done_o[k],    e_dd);
        check_bit ("mem_en",    k, mem_en_o[k],    e_en);
        check_bit ("mem_wr",    k, mem_wr_o[k],    e_wr);
        check_bit ("busy",      k, busy_o[k],      e_busy);
        check_word("mem_addr",  k, mem_addr_o[k],  e_addr);
        check_word("mem_wdata", k, mem_wdata_o[k], e_wd);
        check_word("if_rdata",  k, if_rdata_o[k],  exp_ifr[k]);
        check_word("d_rdata",   k, d_rdata_o[k],   exp_dr[k]);

        if (grant) begin
            a            = e_addr;
            pend_v[k]    = 1'b1;
            pend_if[k]   = !win_d;
            pend_wr[k]   = e_wr;
            pend_done[k] = cyc + lat_of(k) + 1;
            pend_data[k] = shadow_w[k][a[9:2]] ? shadow[k][a[9:2]] : init_word(a);
            if (e_wr) begin
                shadow[k][a[9:2]]   = e_wd;
                shadow_w[k][a[9:2]] = 1'b1;
            end
        end
        if (!if_req_v[k] || e_ifg) starve[k] = 0;
        else if (e_dg && starve[k] < STARVE_MAX) starve[k] = starve[k] + 1;
    endtask

    task automatic apply_stimulus();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        if_req_v = '0;
        d_req_v  = '0;
        d_wr_v   = '0;
        for (int k = 0; k < 2; k++) begin
            if_addr_v[k] = '0;
            d_addr_v[k]  = '0;
            d_wdata_v[k] = '0;
        end
        fork
            forever begin
                @(negedge clk);
                for (int k = 0; k < 2; k++) check_output(k);
                cyc++;
            end
        join_none

        apply_stimulus();
        apply_stimulus();
        rst = 1'b0;
        @(negedge clk);
        check_bit ("rst_busy",     0, busy_o[0],     1'b0);
        check_bit ("rst_mem_en",   0, mem_en_o[0],   1'b0);
        check_word("rst_if_rdata", 0, if_rdata_o[0], 32'h0);
        check_word("rst_d_rdata",  0, d_rdata_o[0],  32'h0);

        // Single fetch with MEM_LAT=1.
        apply_stimulus();
        if_req_v[0] = 1'b1; if_addr_v[0] = 32'h10;
        @(negedge clk);
        check_bit ("t1_if_gnt",   0, if_gnt_o[0],   1'b1);
        check_bit ("t1_mem_en",   0, mem_en_o[0],   1'b1);
        check_bit ("t1_mem_wr",   0, mem_wr_o[0],   1'b0);
        check_word("t1_mem_addr", 0, mem_addr_o[0], 32'h10);
        apply_stimulus();
        if_req_v[0] = 1'b0;
        apply_stimulus();
        @(negedge clk);
        check_bit ("t1_if_done",  0, if_done_o[0],  1'b1);
        check_word("t1_if_rdata", 0, if_rdata_o[0], 32'hDEAD_BEEF);

        // Simultaneous requests: D first, IF back-to-back in D's done cycle.
        apply_stimulus();
        if_req_v[0] = 1'b1; if_addr_v[0] = 32'h10;
        d_req_v[0]  = 1'b1; d_wr_v[0] = 1'b0; d_addr_v[0] = 32'h40;
        @(negedge clk);
        check_bit("t2_d_gnt_c0",  0, d_gnt_o[0],  1'b1);
        check_bit("t2_if_gnt_c0", 0, if_gnt_o[0], 1'b0);
        apply_stimulus();
        d_req_v[0] = 1'b0;
        apply_stimulus();
        @(negedge clk);
        check_bit ("t2_d_done_c2", 0, d_done_o[0],  1'b1);
        check_bit ("t2_if_gnt_c2", 0, if_gnt_o[0],  1'b1);
        check_word("t2_d_rdata",   0, d_rdata_o[0], 32'h5A5A_0040);
        apply_stimulus();
        if_req_v[0] = 1'b0;
        apply_stimulus();
        @(negedge clk);
        check_bit("t2_if_done_c4", 0, if_done_o[0], 1'b1);

        // Write, then read it back through the fetch port.
        apply_stimulus();
        d_req_v[0] = 1'b1; d_wr_v[0] = 1'b1; d_addr_v[0] = 32'h20; d_wdata_v[0] = 32'h1234;
        @(negedge clk);
        check_bit ("t3_mem_wr",    0, mem_wr_o[0],    1'b1);
        check_word("t3_mem_wdata", 0, mem_wdata_o[0], 32'h1234);
        apply_stimulus();
        d_req_v[0] = 1'b0; d_wr_v[0] = 1'b0;
        apply_stimulus();
        @(negedge clk);
        check_bit ("t3_d_done",  0, d_done_o[0],  1'b1);
        check_word("t3_d_rdata", 0, d_rdata_o[0], 32'h5A5A_0040);
        apply_stimulus();
        if_req_v[0] = 1'b1; if_addr_v[0] = 32'h20;
        apply_stimulus();
        if_req_v[0] = 1'b0;
        apply_stimulus();
        @(negedge clk);
        check_word("t3_if_rdata", 0, if_rdata_o[0], 32'h1234);

        // Both held: four D grants then the starvation override hands IF the fifth slot.
        apply_stimulus();
        if_req_v[0] = 1'b1; if_addr_v[0] = 32'h14;
        d_req_v[0]  = 1'b1; d_wr_v[0] = 1'b0; d_addr_v[0] = 32'h44;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) apply_stimulus();
            @(negedge clk);
            check_bit($sformatf("t4_d_gnt_c%0d", i),  0, d_gnt_o[0],  (i % 2 == 0) && (i < 8));
            check_bit($sformatf("t4_if_gnt_c%0d", i), 0, if_gnt_o[0], i == 8);
        end
        apply_stimulus();
        if_req_v[0] = 1'b0; d_req_v[0] = 1'b0;
        apply_stimulus();

        // Reset during WAIT discards the in-flight read.
        apply_stimulus();
        d_req_v[0] = 1'b1; d_wr_v[0] = 1'b0; d_addr_v[0] = 32'h48;
        @(negedge clk);
        check_bit("t5_d_gnt", 0, d_gnt_o[0], 1'b1);
        apply_stimulus();
        d_req_v[0] = 1'b0; rst = 1'b1;
        apply_stimulus();
        rst = 1'b0;
        @(negedge clk);
        check_bit ("t5_d_done",   0, d_done_o[0],   1'b0);
        check_bit ("t5_busy",     0, busy_o[0],     1'b0);
        check_bit ("t5_mem_en",   0, mem_en_o[0],   1'b0);
        check_word("t5_d_rdata",  0, d_rdata_o[0],  32'h0);
        check_word("t5_if_rdata", 0, if_rdata_o[0], 32'h0);
        apply_stimulus();
        if_req_v[0] = 1'b1; if_addr_v[0] = 32'h10;
        @(negedge clk);
        check_bit("t5_if_gnt", 0, if_gnt_o[0], 1'b1);
        apply_stimulus();
        if_req_v[0] = 1'b0;
        apply_stimulus();

        // MEM_LAT=3 instance: done four cycles after grant, busy for three.
        apply_stimulus();
        if_req_v[1] = 1'b1; if_addr_v[1] = 32'h10;
        @(negedge clk);
        check_bit("t6_if_gnt", 1, if_gnt_o[1], 1'b1);
        check_bit("t6_busy_c0", 1, busy_o[1],  1'b0);
        for (int i = 1; i <= 3; i++) begin
            apply_stimulus();
            if (i == 1) if_req_v[1] = 1'b0;
            @(negedge clk);
            check_bit($sformatf("t6_busy_c%0d", i),    1, busy_o[1],    1'b1);
            check_bit($sformatf("t6_if_done_c%0d", i), 1, if_done_o[1], 1'b0);
        end
        apply_stimulus();
        @(negedge clk);
        check_bit ("t6_if_done_c4", 1, if_done_o[1],  1'b1);
        check_bit ("t6_busy_c4",    1, busy_o[1],     1'b0);
        check_word("t6_if_rdata",   1, if_rdata_o[1], 32'hDEAD_BEEF);

        repeat (3) apply_stimulus();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
